// File: rtl/mesh_link_stage.sv
// Pipelined inter-router link: flit and credit channels each pass through LINK_STAGES registers,
// with a sender-side per-VC credit monitor and sticky error. Optional flit counter: MESH_LINK_PERF_EN.
module mesh_link_stage #(
    parameter int CHANNEL_WIDTH   = 340,
    parameter int FLOW_CTRL_WIDTH = 10,
    parameter int NUM_VCS         = 4,
    parameter int BUFFER_DEPTH    = 8,
    parameter int LINK_STAGES     = 2,
    localparam int VC_IDX_W       = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int CRED_W         = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [0:CHANNEL_WIDTH-1]   channel_in,
    output logic [0:CHANNEL_WIDTH-1]   channel_out,
    input  logic [0:FLOW_CTRL_WIDTH-1] flow_ctrl_in,
    output logic [0:FLOW_CTRL_WIDTH-1] flow_ctrl_out,
    output logic                       error,
    output logic [VC_IDX_W-1:0]        error_vc,
    output logic                       error_ovf
`ifdef MESH_LINK_PERF_EN
    ,
    output logic [31:0]                flit_count
`endif
);

    localparam logic [CRED_W-1:0]   DEPTH_L   = CRED_W'(BUFFER_DEPTH);
    localparam logic [VC_IDX_W:0]   NUM_VCS_L = (VC_IDX_W + 1)'(NUM_VCS);

    generate
        if (LINK_STAGES == 0) begin : g_comb
            assign channel_out   = channel_in;
            assign flow_ctrl_out = flow_ctrl_in;
        end else begin : g_pipe
            logic [0:CHANNEL_WIDTH-1]   r_chan [LINK_STAGES];
            logic [0:FLOW_CTRL_WIDTH-1] r_flow [LINK_STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LINK_STAGES; i++) begin
                        r_chan[i] <= '0;
                        r_flow[i] <= '0;
                    end
                end else begin
                    r_chan[0] <= channel_in;
                    r_flow[0] <= flow_ctrl_in;
                    for (int i = 1; i < LINK_STAGES; i++) begin
                        r_chan[i] <= r_chan[i-1];
                        r_flow[i] <= r_flow[i-1];
                    end
                end
            end

            assign channel_out   = r_chan[LINK_STAGES-1];
            assign flow_ctrl_out = r_flow[LINK_STAGES-1];
        end
    endgenerate

    // The monitor takes the sender's view: flits leaving it, credits arriving at it.
    logic                w_fv;
    logic                w_cv;
    logic [VC_IDX_W-1:0] w_vin;
    logic [VC_IDX_W-1:0] w_vout;
    logic                w_vin_ok;
    logic                w_vout_ok;
    logic [NUM_VCS-1:0]  w_uf_vc;
    logic [NUM_VCS-1:0]  w_ovf_vc;
    logic                w_flag_uf;
    logic                w_flag_ovf;

    assign w_fv      = channel_in[0];
    assign w_vin     = channel_in[1 +: VC_IDX_W];
    assign w_cv      = flow_ctrl_out[0];
    assign w_vout    = flow_ctrl_out[1 +: VC_IDX_W];
    assign w_vin_ok  = ({1'b0, w_vin} < NUM_VCS_L);
    assign w_vout_ok = ({1'b0, w_vout} < NUM_VCS_L);

    generate
        for (genvar gi = 0; gi < NUM_VCS; gi++) begin : g_vc
            logic              w_take;
            logic              w_give;
            logic [CRED_W-1:0] r_credit;

            // A flit and a credit on the same VC cancel, so neither can trip a bound.
            assign w_take = w_fv && (w_vin == VC_IDX_W'(gi)) && !(w_cv && (w_vout == VC_IDX_W'(gi)));
            assign w_give = w_cv && (w_vout == VC_IDX_W'(gi)) && !(w_fv && (w_vin == VC_IDX_W'(gi)));
            assign w_uf_vc[gi]  = w_take && (r_credit == '0);
            assign w_ovf_vc[gi] = w_give && (r_credit == DEPTH_L);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_credit <= DEPTH_L;
                end else if (w_take && !w_uf_vc[gi]) begin
                    r_credit <= r_credit - CRED_W'(1);
                end else if (w_give && !w_ovf_vc[gi]) begin
                    r_credit <= r_credit + CRED_W'(1);
                end
            end
        end
    endgenerate

    assign w_flag_uf  = w_fv && (!w_vin_ok || (|w_uf_vc));
    assign w_flag_ovf = w_cv && (!w_vout_ok || (|w_ovf_vc));

    logic                r_error;
    logic [VC_IDX_W-1:0] r_error_vc;
    logic                r_error_ovf;

    // Only the first flag is recorded; a flit error beats a simultaneous credit error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error     <= 1'b0;
            r_error_vc  <= '0;
            r_error_ovf <= 1'b0;
        end else if (!r_error) begin
            if (w_flag_uf) begin
                r_error     <= 1'b1;
                r_error_vc  <= w_vin;
                r_error_ovf <= 1'b0;
            end else if (w_flag_ovf) begin
                r_error     <= 1'b1;
                r_error_vc  <= w_vout;
                r_error_ovf <= 1'b1;
            end
        end
    end

    assign error     = r_error;
    assign error_vc  = r_error_vc;
    assign error_ovf = r_error_ovf;

`ifdef MESH_LINK_PERF_EN
    logic [31:0] r_flit_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flit_count <= '0;
        end else begin
            r_flit_count <= r_flit_count + 32'(channel_out[0]);
        end
    end

    assign flit_count = r_flit_count;
`endif

endmodule
